// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver with a single-byte holding register.
// Start is confirmed at mid-bit, then data and stop are sampled at bit centres.
module uart_rx_os #(
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 tick,
    input  logic                 rxd,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ok_q, ok_d;
    logic                 bad_q, bad_d;
    logic                 sync1_q, sync2_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q;
    logic                 ovr_q, ovr_d;
    logic                 rxs;

    assign rxs = sync2_q;

    // Synchronizer idles high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ok_d    = 1'b0;
        bad_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    // Leave on the stop sample so a back-to-back start is seen.
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        ok_d    = rxs;
                        bad_d   = !rxs;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ok_q) begin
            if (valid_q && !rd) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
                if (rd) begin
                    ovr_d = 1'b0;
                end
            end
        end else if (rd) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= bad_q;
            ovr_q   <= ovr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and random frames against a tick-indexed model.
// The model derives sample instants from the start tick by plain arithmetic.
module tb_uart_rx_os;

    localparam int OS     = 4;
    localparam int DB     = 8;
    localparam int TDIV   = 4;
    localparam int BITCLK = OS * TDIV;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          tick   = 1'b0;
    logic          rxd    = 1'b1;
    logic          rd     = 1'b0;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;
    bit tick_en = 1'b1;
    bit rd_rand = 1'b0;
    int tdiv    = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    bit busy_cnt_en = 1'b0;

    uart_rx_os #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .tick     (tick),
        .rxd      (rxd),
        .rd       (rd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: line history indexed by tick number since reset.
    logic          m_s1, m_s2, m_rxs;
    int            m_tk, m_t0, m_off, m_j;
    bit            m_busy, m_ok, m_bad, m_nok, m_nbad;
    bit            m_valid, m_ovr, m_ferr;
    logic [DB-1:0] m_sh, m_pend, m_data;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_tk = 0; m_t0 = 0;
            m_busy = 1'b0; m_ok = 1'b0; m_bad = 1'b0;
            m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
            m_data = '0; m_sh = '0; m_pend = '0;
        end else begin
            m_rxs = m_s2; m_nok = 1'b0; m_nbad = 1'b0;
            if (tick) begin
                if (!m_busy) begin
                    if (!m_rxs) begin
                        m_busy = 1'b1;
                        m_t0   = m_tk;
                    end
                end else begin
                    m_off = m_tk - m_t0;
                    if (m_off == OS / 2) begin
                        if (m_rxs) m_busy = 1'b0;
                    end else if (m_off > OS / 2 && (m_off - OS / 2) % OS == 0) begin
                        m_j = (m_off - OS / 2) / OS;
                        if (m_j <= DB) m_sh[m_j-1] = m_rxs;
                        else begin
                            m_busy = 1'b0;
                            m_nok  = m_rxs;
                            m_nbad = !m_rxs;
                        end
                    end
                end
                m_tk++;
            end
            m_ferr = m_bad;
            if (m_ok) begin
                if (m_valid && !rd) m_ovr = 1'b1;
                else begin
                    m_data = m_pend; m_valid = 1'b1;
                    if (rd) m_ovr = 1'b0;
                end
            end else if (rd) begin
                m_valid = 1'b0; m_ovr = 1'b0;
            end
            m_ok = m_nok; m_bad = m_nbad;
            if (m_nok) m_pend = m_sh;
            m_s2 = m_s1; m_s1 = rxd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("data", 32'(data), 32'(m_data));
            check("valid", 32'(valid), 32'(m_valid));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("busy", 32'(busy), 32'(m_busy));
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (busy_cnt_en && busy === 1'b1) busy_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            tdiv = (tdiv + 1) % TDIV;
            tick = tick_en && (tdiv == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rd_rand) rd = ($urandom_range(0, 9) == 0);
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic send_frame(logic [DB-1:0] b, logic stop);
        rxd = 1'b0; cyc(BITCLK);
        for (int i = 0; i < DB; i++) begin
            rxd = b[i]; cyc(BITCLK);
        end
        rxd = stop; cyc(BITCLK);
        rxd = 1'b1;
    endtask

    task automatic pop();
        rd = 1'b1; cyc(1); rd = 1'b0;
    endtask

    initial begin
        cyc(2);
        cmp_en = 1'b1;
        cyc(1);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        resetn = 1'b1;
        cyc(4);

        ferr_cnt = 0;
        send_frame(8'hA5, 1'b1); cyc(4);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_valid", 32'(valid), 32'h1);
        check("a5_model", 32'(m_data), 32'hA5);
        check("a5_no_ferr", 32'(ferr_cnt), 32'h0);
        pop();
        check("a5_read", 32'(valid), 32'h0);

        ferr_cnt = 0;
        send_frame(8'h3C, 1'b0); cyc(24);
        check("3c_ferr_pulses", 32'(ferr_cnt), 32'h1);
        check("3c_valid", 32'(valid), 32'h0);
        check("3c_data_kept", 32'(data), 32'hA5);

        ferr_cnt = 0; busy_cnt = 0; busy_cnt_en = 1'b1;
        rxd = 1'b0; cyc(TDIV); rxd = 1'b1; cyc(24);
        busy_cnt_en = 1'b0;
        check("glitch_busy_clks", 32'(busy_cnt), 32'(2 * TDIV));
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt), 32'h0);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1); cyc(4);
        check("ovr_data", 32'(data), 32'h11);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        pop();
        check("ovr_rd_valid", 32'(valid), 32'h0);
        check("ovr_rd_flag", 32'(overrun), 32'h0);

        send_frame(8'h55, 1'b1);
        fork
            send_frame(8'hAA, 1'b1);
            begin
                for (int k = 0; k < 12 * BITCLK && !m_ok; k++) cyc(1);
                if (!m_ok) check("aa_timeout", 32'h0, 32'h1);
                else pop();
            end
        join
        cyc(4);
        check("same_clk_data", 32'(data), 32'hAA);
        check("same_clk_valid", 32'(valid), 32'h1);
        check("same_clk_ovr", 32'(overrun), 32'h0);
        pop();

        send_frame(8'h5A, 1'b1); cyc(2);
        tick_en = 1'b0; cyc(8);
        pop();
        check("frozen_rd", 32'(valid), 32'h0);
        rxd = 1'b0; cyc(20);
        check("frozen_busy", 32'(busy), 32'h0);
        rxd = 1'b1; cyc(10);
        tick_en = 1'b1; cyc(8);

        send_frame(8'h77, 1'b1); cyc(4);
        check("pre_rst_valid", 32'(valid), 32'h1);
        fork
            send_frame(8'hF3, 1'b1);
            begin
                cyc(BITCLK * 5 + 8);
                resetn = 1'b0;
                #1;
                check("mid_rst_data", 32'(data), 32'h0);
                check("mid_rst_valid", 32'(valid), 32'h0);
                check("mid_rst_busy", 32'(busy), 32'h0);
                check("mid_rst_ferr", 32'(frame_err), 32'h0);
                check("mid_rst_ovr", 32'(overrun), 32'h0);
            end
        join
        cyc(2); resetn = 1'b1; cyc(4);
        ferr_cnt = 0;
        send_frame(8'h0F, 1'b1); cyc(4);
        check("post_rst_data", 32'(data), 32'h0F);
        check("post_rst_valid", 32'(valid), 32'h1);
        check("post_rst_ferr", 32'(ferr_cnt), 32'h0);
        pop();

        rd_rand = 1'b1;
        for (int it = 0; it < 120; it++) begin
            int r;
            cyc($urandom_range(0, 30));
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rxd = 1'b0; cyc($urandom_range(1, 8)); rxd = 1'b1;
            end else if (r == 1) begin
                tick_en = 1'b0; cyc($urandom_range(1, 40)); tick_en = 1'b1;
            end else if (r == 2) begin
                resetn = 1'b0; cyc(2); resetn = 1'b1;
            end else begin
                send_frame(DB'($urandom), ($urandom_range(0, 7) != 0));
            end
        end
        rd_rand = 1'b0; rd = 1'b0;
        cyc(200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 4, giving the tick count per bit period; legal values are even and at least 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge of clk.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tick, input, 1 bit: a one-clk enable at OVERSAMPLE x baud, sourced from baudgen.
REQ-006 The block SHALL have port rxd, input, 1 bit: the asynchronous serial line, idle high.
REQ-007 The block SHALL have port rd, input, 1 bit: the consumer acknowledge; a high level pops the held byte.
REQ-008 The block SHALL have port data, output, DATA_BITS wide: the holding register.
REQ-009 The block SHALL have port valid, output, 1 bit: high while the holding register contains an unread byte.
REQ-010 The block SHALL have port frame_err, output, 1 bit: a one-clk pulse when a bad stop bit is sampled.
REQ-011 The block SHALL have port overrun, output, 1 bit: a sticky flag set when a byte is lost.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value rxs.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP; the FSM and the tick counter SHALL advance only on clocks where tick=1.
REQ-015 In IDLE, a tick with rxs=0 SHALL move the FSM to START and clear the tick counter; this tick is T0.
REQ-016 In START, at T0+OVERSAMPLE/2, rxs=0 SHALL move the FSM to DATA; rxs=1 SHALL be treated as a glitch, returning the FSM to IDLE with no outputs changed.
REQ-017 In DATA, bit n SHALL be sampled LSB first at tick T0+OVERSAMPLE/2+OVERSAMPLE*(n+1), for n = 0..DATA_BITS-1, into a shift register.
REQ-018 In STOP, the stop bit SHALL be sampled at T0+OVERSAMPLE/2+OVERSAMPLE*(DATA_BITS+1).
REQ-019 The FSM SHALL return to IDLE on the same tick as the stop sample, so that a back-to-back start edge is detectable half a bit period later.
REQ-020 On a stop sample of 1, on the following clk, data SHALL load the shift register and valid SHALL be set.
REQ-021 On a stop sample of 0, frame_err SHALL pulse high for exactly one clk, and neither data nor valid SHALL change.
REQ-022 With rd=1 and valid=1 on a clk edge, valid SHALL clear on that edge; rd with valid=0 SHALL be ignored.
REQ-023 When a byte completes while valid=1 and rd=0, the new byte SHALL be discarded, data SHALL keep the old byte, and overrun SHALL set.
REQ-024 When a byte completes on the same clk as rd=1, the new byte SHALL load, valid SHALL stay 1, and overrun SHALL not set.
REQ-025 overrun SHALL clear on any clk with rd=1, except in the REQ-023 case.
REQ-026 The tick counter SHALL be log2(OVERSAMPLE) bits and wrap modulo OVERSAMPLE.
REQ-027 The bit counter SHALL count 0..DATA_BITS-1, with no wrap past DATA_BITS-1.
REQ-028 tick=0 for any duration SHALL freeze the FSM; rd processing SHALL continue while the FSM is frozen.

Reset
REQ-029 resetn=0 SHALL asynchronously force: FSM to IDLE; counters to 0; synchronizer flops to 1; data to 0; valid=0, frame_err=0, overrun=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame without any valid or frame_err output.
REQ-031 After resetn deasserts, the first detectable start SHALL be a falling edge observed after the synchronizer has filled with 1s.

Verification
REQ-032 Scenario: tick every 4 clk, OVERSAMPLE=4, frame 0xA5 with stop=1 -> valid rises, data=0xA5, frame_err never high.
REQ-033 Scenario: frame 0x3C with stop=0 -> one-clk frame_err pulse, valid stays 0, data unchanged.
REQ-034 Scenario: rxd low pulse of 1 tick while IDLE -> FSM returns to IDLE at T0+2, no outputs, busy high for exactly 2 ticks.
REQ-035 Scenario: frames 0x11 then 0x22 back-to-back, rd held 0 -> data=0x11, overrun=1; then rd=1 -> valid=0, overrun=0.
REQ-036 Scenario: frames 0x55 then 0xAA, with rd=1 on the clk where 0xAA completes -> data=0xAA, valid=1, overrun=0.
REQ-037 Scenario: resetn pulsed low during bit 4 of a frame -> all outputs 0 immediately, and the next full frame 0x0F is received correctly.
